// File: rtl/mmu_utlb_if.sv
// Purpose: shared types and the lookup/refill bundle for the micro-TLB.
// Ports:   master = CPU pipeline + main TLB side, slave = mmu_utlb.
//          Lookup: req_valid/req_vaddr in, resp_valid/resp_result out (per port).
//          Refill: refill_req/refill_vaddr out, refill_ack/refill_result/refill_global in.
package mmu_utlb_pkg;
  typedef logic [31:0] virt_t;

  typedef struct packed {
    logic [31:0] phy_addr;
    logic [31:0] virt_addr;
    logic        miss;
    logic        illegal;
    logic        invalid;
    logic        dirty;
    logic        uncached;
  } mmu_result_t;

  typedef struct packed {
    logic [31:0] phy_addr;
    logic        miss;
    logic        valid;
    logic        dirty;
    logic [2:0]  cache_flag;
  } tlb_result_t;
endpackage

interface mmu_utlb_if #(
  parameter int PORTS = 3
);
  import mmu_utlb_pkg::*;

  logic        [PORTS-1:0] req_valid;
  virt_t       [PORTS-1:0] req_vaddr;
  logic        [PORTS-1:0] resp_valid;
  mmu_result_t [PORTS-1:0] resp_result;

  logic        refill_req;
  virt_t       refill_vaddr;
  logic        refill_ack;
  tlb_result_t refill_result;
  logic        refill_global;

  modport slave (
    input  req_valid, req_vaddr, refill_ack, refill_result, refill_global,
    output resp_valid, resp_result, refill_req, refill_vaddr
  );

  modport master (
    output req_valid, req_vaddr, refill_ack, refill_result, refill_global,
    input  resp_valid, resp_result, refill_req, refill_vaddr
  );
endinterface

// File: rtl/mmu_utlb.sv
// Purpose: fully-associative micro-TLB in front of the main TLB, PORTS lookup ports.
// Latency: unmapped/hit/fault lookups resolve combinationally; a miss refills via one handshake.
// Backpressure: a missing port sees resp_valid=0 until its refill lands (hit the cycle after ack).
// Ports: clk, rst_n (async active-low), asid, is_user_mode, kseg0_uncached, flush,
//        bus (mmu_utlb_if.slave: lookup and refill handshake).
// Optional: define MMU_UTLB_PERF_EN to add saturating perf_hit/perf_miss counters.
module mmu_utlb
  import mmu_utlb_pkg::*;
#(
  parameter int PORTS   = 3,
  parameter int ENTRIES = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  asid,
  input  logic        is_user_mode,
  input  logic        kseg0_uncached,
  input  logic        flush,
  mmu_utlb_if.slave   bus
`ifdef MMU_UTLB_PERF_EN
  ,
  output logic [31:0] perf_hit,
  output logic [31:0] perf_miss
`endif
);
  localparam int IDXW = $clog2(ENTRIES);

  typedef enum logic {IDLE, REQ} state_e;

  state_e      state_q, state_d;
  logic        refill_req_q, refill_req_d;
  virt_t       refill_vaddr_q, refill_vaddr_d;
  logic [7:0]  ref_asid_q, ref_asid_d;
  logic        drop_q, drop_d;
  logic [IDXW-1:0] rr_q, rr_d;

  logic [ENTRIES-1:0] ent_valid_q, ent_valid_d;
  logic [19:0] ent_vpn_q   [ENTRIES];
  logic [19:0] ent_vpn_d   [ENTRIES];
  logic [19:0] ent_pfn_q   [ENTRIES];
  logic [19:0] ent_pfn_d   [ENTRIES];
  logic [7:0]  ent_asid_q  [ENTRIES];
  logic [7:0]  ent_asid_d  [ENTRIES];
  logic [2:0]  ent_cf_q    [ENTRIES];
  logic [2:0]  ent_cf_d    [ENTRIES];
  logic [ENTRIES-1:0] ent_g_q, ent_g_d, ent_dirty_q, ent_dirty_d;

  // A failed refill parks here so the requester gets exactly one faulting answer.
  logic        flt_valid_q, flt_valid_d;
  logic [19:0] flt_vpn_q, flt_vpn_d;
  logic [7:0]  flt_asid_q, flt_asid_d;
  logic        flt_miss_q, flt_miss_d;
  logic        flt_invalid_q, flt_invalid_d;

  logic [PORTS-1:0] stall, mapped_hit, flt_hit;

  for (genvar gp = 0; gp < PORTS; gp++) begin : g_port
    virt_t           va;
    logic            hit;
    logic [IDXW-1:0] hidx;
    logic            vld, stl, mh, fh;
    mmu_result_t     res;

    assign va = bus.req_vaddr[gp];

    always_comb begin
      hit  = 1'b0;
      hidx = '0;
      for (int e = 0; e < ENTRIES; e++) begin
        if (!hit && ent_valid_q[e] && ent_vpn_q[e] == va[31:12] &&
            (ent_g_q[e] || ent_asid_q[e] == asid)) begin
          hit  = 1'b1;
          hidx = e[IDXW-1:0];
        end
      end
    end

    always_comb begin
      res           = '0;
      res.virt_addr = va;
      vld = 1'b0;
      stl = 1'b0;
      mh  = 1'b0;
      fh  = 1'b0;
      if (bus.req_valid[gp]) begin
        if (is_user_mode && va[31]) begin
          vld         = 1'b1;
          res.illegal = 1'b1;
        end else if (va[31:30] == 2'b10) begin
          vld          = 1'b1;
          res.phy_addr = {3'b000, va[28:0]};
          res.dirty    = 1'b1;
          res.uncached = (va[31:29] == 3'b101) || (kseg0_uncached && va[31:29] == 3'b100);
        end else if (hit) begin
          vld          = 1'b1;
          mh           = 1'b1;
          res.phy_addr = {ent_pfn_q[hidx], va[11:0]};
          res.dirty    = ent_dirty_q[hidx];
          res.uncached = (ent_cf_q[hidx] == 3'd2);
        end else if (flt_valid_q && flt_vpn_q == va[31:12] && flt_asid_q == asid) begin
          vld         = 1'b1;
          fh          = 1'b1;
          res.miss    = flt_miss_q;
          res.invalid = flt_invalid_q;
        end else begin
          stl = 1'b1;
        end
      end
    end

    assign bus.resp_valid[gp]  = vld;
    assign bus.resp_result[gp] = res;
    assign stall[gp]           = stl;
    assign mapped_hit[gp]      = mh;
    assign flt_hit[gp]         = fh;
  end

  // Lowest-index stalled port wins the refill slot.
  virt_t sel_va;
  always_comb begin
    sel_va = '0;
    for (int p = PORTS - 1; p >= 0; p--) begin
      if (stall[p]) sel_va = bus.req_vaddr[p];
    end
  end

  // Victim: first free slot, else the round-robin pointer.
  logic            free_found;
  logic [IDXW-1:0] victim;
  always_comb begin
    free_found = 1'b0;
    victim     = rr_q;
    for (int e = 0; e < ENTRIES; e++) begin
      if (!free_found && !ent_valid_q[e]) begin
        free_found = 1'b1;
        victim     = e[IDXW-1:0];
      end
    end
  end

  logic refill_start;
  assign refill_start = (state_q == IDLE) && (|stall) && !flush;

  always_comb begin
    state_d        = state_q;
    refill_req_d   = refill_req_q;
    refill_vaddr_d = refill_vaddr_q;
    ref_asid_d     = ref_asid_q;
    drop_d         = drop_q;
    rr_d           = rr_q;
    ent_valid_d    = ent_valid_q;
    ent_vpn_d      = ent_vpn_q;
    ent_pfn_d      = ent_pfn_q;
    ent_asid_d     = ent_asid_q;
    ent_cf_d       = ent_cf_q;
    ent_g_d        = ent_g_q;
    ent_dirty_d    = ent_dirty_q;
    flt_valid_d    = flt_valid_q && !(|flt_hit);
    flt_vpn_d      = flt_vpn_q;
    flt_asid_d     = flt_asid_q;
    flt_miss_d     = flt_miss_q;
    flt_invalid_d  = flt_invalid_q;

    case (state_q)
      IDLE: begin
        if (refill_start) begin
          state_d        = REQ;
          refill_req_d   = 1'b1;
          refill_vaddr_d = sel_va;
          ref_asid_d     = asid;
          drop_d         = 1'b0;
        end
      end
      REQ: begin
        if (flush) drop_d = 1'b1;
        if (bus.refill_ack) begin
          state_d      = IDLE;
          refill_req_d = 1'b0;
          drop_d       = 1'b0;
          if (!(drop_q || flush)) begin
            if (bus.refill_result.miss || !bus.refill_result.valid) begin
              flt_valid_d   = 1'b1;
              flt_vpn_d     = refill_vaddr_q[31:12];
              flt_asid_d    = ref_asid_q;
              flt_miss_d    = bus.refill_result.miss;
              flt_invalid_d = !bus.refill_result.miss;
            end else begin
              ent_valid_d[victim] = 1'b1;
              ent_vpn_d[victim]   = refill_vaddr_q[31:12];
              ent_pfn_d[victim]   = bus.refill_result.phy_addr[31:12];
              ent_asid_d[victim]  = ref_asid_q;
              ent_cf_d[victim]    = bus.refill_result.cache_flag;
              ent_g_d[victim]     = bus.refill_global;
              ent_dirty_d[victim] = bus.refill_result.dirty;
              if (!free_found) rr_d = rr_q + 1'b1;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (flush) begin
      ent_valid_d = '0;
      flt_valid_d = 1'b0;
      rr_d        = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      refill_req_q   <= 1'b0;
      refill_vaddr_q <= '0;
      ref_asid_q     <= '0;
      drop_q         <= 1'b0;
      rr_q           <= '0;
      ent_valid_q    <= '0;
      ent_g_q        <= '0;
      ent_dirty_q    <= '0;
      for (int e = 0; e < ENTRIES; e++) begin
        ent_vpn_q[e]  <= '0;
        ent_pfn_q[e]  <= '0;
        ent_asid_q[e] <= '0;
        ent_cf_q[e]   <= '0;
      end
      flt_valid_q    <= 1'b0;
      flt_vpn_q      <= '0;
      flt_asid_q     <= '0;
      flt_miss_q     <= 1'b0;
      flt_invalid_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      refill_req_q   <= refill_req_d;
      refill_vaddr_q <= refill_vaddr_d;
      ref_asid_q     <= ref_asid_d;
      drop_q         <= drop_d;
      rr_q           <= rr_d;
      ent_valid_q    <= ent_valid_d;
      ent_g_q        <= ent_g_d;
      ent_dirty_q    <= ent_dirty_d;
      ent_vpn_q      <= ent_vpn_d;
      ent_pfn_q      <= ent_pfn_d;
      ent_asid_q     <= ent_asid_d;
      ent_cf_q       <= ent_cf_d;
      flt_valid_q    <= flt_valid_d;
      flt_vpn_q      <= flt_vpn_d;
      flt_asid_q     <= flt_asid_d;
      flt_miss_q     <= flt_miss_d;
      flt_invalid_q  <= flt_invalid_d;
    end
  end

  assign bus.refill_req   = refill_req_q;
  assign bus.refill_vaddr = refill_vaddr_q;

`ifdef MMU_UTLB_PERF_EN
  logic [31:0] perf_hit_q, perf_hit_d, perf_miss_q, perf_miss_d;
  logic [32:0] hit_sum;

  always_comb begin
    hit_sum = {1'b0, perf_hit_q};
    for (int p = 0; p < PORTS; p++) hit_sum = hit_sum + {32'd0, mapped_hit[p]};
    perf_hit_d  = hit_sum[32] ? 32'hFFFF_FFFF : hit_sum[31:0];
    perf_miss_d = (refill_start && perf_miss_q != 32'hFFFF_FFFF) ? perf_miss_q + 32'd1 : perf_miss_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_hit_q  <= '0;
      perf_miss_q <= '0;
    end else begin
      perf_hit_q  <= perf_hit_d;
      perf_miss_q <= perf_miss_d;
    end
  end

  assign perf_hit  = perf_hit_q;
  assign perf_miss = perf_miss_q;
`endif
endmodule

// File: tb/tb_mmu_utlb.sv
module tb_mmu_utlb;
  import mmu_utlb_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] asid;
  logic       is_user_mode, kseg0_uncached, flush;
`ifdef MMU_UTLB_PERF_EN
  logic [31:0] perf_hit, perf_miss;
  logic [31:0] h0, m0;
`endif

  mmu_utlb_if #(.PORTS(3)) bus();

  mmu_utlb #(.PORTS(3), .ENTRIES(8)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .asid           (asid),
    .is_user_mode   (is_user_mode),
    .kseg0_uncached (kseg0_uncached),
    .flush          (flush),
    .bus            (bus)
`ifdef MMU_UTLB_PERF_EN
    ,
    .perf_hit       (perf_hit),
    .perf_miss      (perf_miss)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Waits (bounded) for refill_req, checks the address, then acks after `delay` more cycles.
  // Returns 1 ns after the negedge that follows the ack cycle.
  task automatic do_refill(input string name, input logic [31:0] exp_va, input logic [19:0] pfn,
                           input logic miss, input logic vld, input logic dirty, input logic g,
                           input logic [2:0] cf, input int delay);
    int n = 0;
    while (!bus.refill_req && n < 20) begin
      @(negedge clk); #1;
      n++;
    end
    chk({name, " refill_req"}, bus.refill_req, 1);
    chk({name, " refill_vaddr"}, bus.refill_vaddr, exp_va);
    repeat (delay) @(negedge clk);
    @(negedge clk);
    bus.refill_ack                 = 1'b1;
    bus.refill_result.phy_addr     = {pfn, 12'h000};
    bus.refill_result.miss         = miss;
    bus.refill_result.valid        = vld;
    bus.refill_result.dirty        = dirty;
    bus.refill_result.cache_flag   = cf;
    bus.refill_global              = g;
    @(negedge clk);
    bus.refill_ack = 1'b0;
    #1;
  endtask

  typedef struct {
    logic        user;
    logic        k0u;
    logic        rv;
    logic [31:0] va;
    logic        evld;
    logic [31:0] ephy;
    logic        eunc;
    logic        eill;
    logic        edirty;
  } vec_t;

  vec_t vecs[8];

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{1'b0, 1'b0, 1'b1, 32'h8000_1234, 1'b1, 32'h0000_1234, 1'b0, 1'b0, 1'b1};
    vecs[1] = '{1'b0, 1'b1, 1'b1, 32'h8000_1234, 1'b1, 32'h0000_1234, 1'b1, 1'b0, 1'b1};
    vecs[2] = '{1'b0, 1'b0, 1'b1, 32'hA000_0010, 1'b1, 32'h0000_0010, 1'b1, 1'b0, 1'b1};
    vecs[3] = '{1'b0, 1'b0, 1'b1, 32'h9FFF_FFFC, 1'b1, 32'h1FFF_FFFC, 1'b0, 1'b0, 1'b1};
    vecs[4] = '{1'b0, 1'b1, 1'b1, 32'hBFFF_F000, 1'b1, 32'h1FFF_F000, 1'b1, 1'b0, 1'b1};
    vecs[5] = '{1'b1, 1'b0, 1'b1, 32'h8000_0000, 1'b1, 32'h0000_0000, 1'b0, 1'b1, 1'b0};
    vecs[6] = '{1'b1, 1'b0, 1'b1, 32'hFFFF_0000, 1'b1, 32'h0000_0000, 1'b0, 1'b1, 1'b0};
    vecs[7] = '{1'b0, 1'b0, 1'b0, 32'h0040_0000, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b0};

    rst_n = 1'b0; asid = 8'd5; is_user_mode = 1'b0; kseg0_uncached = 1'b0; flush = 1'b0;
    bus.req_valid = '0; bus.req_vaddr = '0;
    bus.refill_ack = 1'b0; bus.refill_result = '0; bus.refill_global = 1'b0;
    #1;
    chk("reset refill_req", bus.refill_req, 0);
    chk("reset refill_vaddr", bus.refill_vaddr, 0);
    chk("reset resp_valid", bus.resp_valid, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Unmapped / illegal / idle lookups on port 0.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      is_user_mode     = vecs[i].user;
      kseg0_uncached   = vecs[i].k0u;
      bus.req_valid    = {2'b00, vecs[i].rv};
      bus.req_vaddr[0] = vecs[i].va;
      #1;
      chk($sformatf("vec%0d resp_valid", i), bus.resp_valid[0], vecs[i].evld);
      if (vecs[i].evld) begin
        chk($sformatf("vec%0d phy", i), bus.resp_result[0].phy_addr, vecs[i].ephy);
        chk($sformatf("vec%0d uncached", i), bus.resp_result[0].uncached, vecs[i].eunc);
        chk($sformatf("vec%0d illegal", i), bus.resp_result[0].illegal, vecs[i].eill);
        chk($sformatf("vec%0d dirty", i), bus.resp_result[0].dirty, vecs[i].edirty);
        chk($sformatf("vec%0d virt", i), bus.resp_result[0].virt_addr, vecs[i].va);
      end
      chk($sformatf("vec%0d refill_req", i), bus.refill_req, 0);
    end
    @(negedge clk);
    bus.req_valid = '0; is_user_mode = 1'b0; kseg0_uncached = 1'b0;
    #1 chk("post-vec refill_req", bus.refill_req, 0);

    // A: single mapped miss on port 1, ASID-tagged entry.
    @(negedge clk);
    asid = 8'd5; bus.req_vaddr[1] = 32'h0040_0ABC; bus.req_valid = 3'b010;
    #1;
    chk("A stall", bus.resp_valid[1], 0);
    chk("A refill_req low", bus.refill_req, 0);
    @(negedge clk); #1;
    chk("A refill_req rise", bus.refill_req, 1);
    do_refill("A", 32'h0040_0ABC, 20'h12300, 1'b0, 1'b1, 1'b0, 1'b0, 3'd3, 1);
    chk("A hit valid", bus.resp_valid[1], 1);
    chk("A hit phy", bus.resp_result[1].phy_addr, 32'h1230_0ABC);
    chk("A hit dirty", bus.resp_result[1].dirty, 0);
    chk("A hit uncached", bus.resp_result[1].uncached, 0);
    chk("A hit miss", bus.resp_result[1].miss, 0);
    asid = 8'd6;
    #1 chk("A asid6 miss", bus.resp_valid[1], 0);
    bus.req_valid = '0; asid = 8'd5;

    // B: ports 0 and 2 miss together; port 0 is served first.
    @(negedge clk);
    bus.req_vaddr[0] = 32'h0001_0000; bus.req_vaddr[2] = 32'h0002_0000; bus.req_valid = 3'b101;
    #1;
    chk("B p0 stall", bus.resp_valid[0], 0);
    chk("B p2 stall", bus.resp_valid[2], 0);
    do_refill("B0", 32'h0001_0000, 20'h00100, 1'b0, 1'b1, 1'b1, 1'b1, 3'd3, 0);
    chk("B p0 hit", bus.resp_valid[0], 1);
    chk("B p0 phy", bus.resp_result[0].phy_addr, 32'h0010_0000);
    chk("B p2 still stalled", bus.resp_valid[2], 0);
    do_refill("B2", 32'h0002_0000, 20'h00200, 1'b0, 1'b1, 1'b1, 1'b1, 3'd2, 0);
    chk("B p2 hit", bus.resp_valid[2], 1);
    chk("B p2 phy", bus.resp_result[2].phy_addr, 32'h0020_0000);
    chk("B p2 uncached", bus.resp_result[2].uncached, 1);
    chk("B p2 dirty", bus.resp_result[2].dirty, 1);
    bus.req_valid = '0;

    // Fill entries 3..7 so the array is full.
    for (int k = 3; k <= 7; k++) begin
      @(negedge clk);
      bus.req_vaddr[0] = 32'(k) << 16; bus.req_valid = 3'b001;
      do_refill($sformatf("fill%0d", k), 32'(k) << 16, 20'(k) << 8, 1'b0, 1'b1, 1'b0, 1'b1, 3'd3, 0);
      chk($sformatf("fill%0d hit", k), bus.resp_valid[0], 1);
      bus.req_valid = '0;
    end

    // Ninth page evicts entry 0 (the ASID-5 page).
    @(negedge clk);
    bus.req_vaddr[0] = 32'h0009_0000; bus.req_valid = 3'b001;
    do_refill("evict0", 32'h0009_0000, 20'h00900, 1'b0, 1'b1, 1'b0, 1'b1, 3'd3, 0);
    chk("evict0 new hit", bus.resp_valid[0], 1);
    bus.req_vaddr[1] = 32'h0040_0ABC; bus.req_vaddr[2] = 32'h0001_0000; bus.req_valid = 3'b111;
    #1;
    chk("evict0 old gone", bus.resp_valid[1], 0);
    chk("evict0 entry1 kept", bus.resp_valid[2], 1);
    bus.req_valid = '0;

    // Tenth page evicts entry 1.
    @(negedge clk);
    bus.req_vaddr[0] = 32'h000A_0000; bus.req_valid = 3'b001;
    do_refill("evict1", 32'h000A_0000, 20'h00A00, 1'b0, 1'b1, 1'b0, 1'b1, 3'd3, 0);
    bus.req_vaddr[1] = 32'h0001_0000; bus.req_vaddr[2] = 32'h0002_0000; bus.req_valid = 3'b111;
    #1;
    chk("evict1 old gone", bus.resp_valid[1], 0);
    chk("evict1 entry2 kept", bus.resp_valid[2], 1);
    bus.req_valid = '0;

    // C: refill answers miss -> one faulting response, no entry written.
    @(negedge clk);
    bus.req_vaddr[0] = 32'h0050_0000; bus.req_valid = 3'b001;
    #1 chk("C stall", bus.resp_valid[0], 0);
    do_refill("C", 32'h0050_0000, 20'h00000, 1'b1, 1'b0, 1'b0, 1'b0, 3'd3, 0);
    chk("C fault valid", bus.resp_valid[0], 1);
    chk("C fault miss", bus.resp_result[0].miss, 1);
    chk("C fault invalid", bus.resp_result[0].invalid, 0);
    bus.req_vaddr[1] = 32'h0009_0000; bus.req_valid = 3'b011;
    #1 chk("C array intact", bus.resp_valid[1], 1);
    bus.req_valid = 3'b001;
    @(negedge clk); #1;
    chk("C fault once", bus.resp_valid[0], 0);
    do_refill("C2", 32'h0050_0000, 20'h00500, 1'b0, 1'b1, 1'b1, 1'b1, 3'd3, 0);
    chk("C2 hit phy", bus.resp_result[0].phy_addr, 32'h0050_0000);
    bus.req_vaddr[1] = 32'h0002_0000; bus.req_vaddr[2] = 32'h0003_0000; bus.req_valid = 3'b111;
    #1;
    chk("C2 evicted entry2", bus.resp_valid[1], 0);
    chk("C2 entry3 kept", bus.resp_valid[2], 1);
    bus.req_valid = '0;

    // Invalid (not miss) answer from the main TLB.
    @(negedge clk);
    bus.req_vaddr[2] = 32'h0070_0000; bus.req_valid = 3'b100;
    do_refill("Cinv", 32'h0070_0000, 20'h00000, 1'b0, 1'b0, 1'b0, 1'b0, 3'd3, 0);
    chk("Cinv valid", bus.resp_valid[2], 1);
    chk("Cinv invalid", bus.resp_result[2].invalid, 1);
    chk("Cinv miss", bus.resp_result[2].miss, 0);
    bus.req_valid = '0;

    // D: flush during REQ drops the result but the handshake completes.
    @(negedge clk);
    bus.req_vaddr[0] = 32'h0060_0000; bus.req_valid = 3'b001;
    #1 chk("D stall", bus.resp_valid[0], 0);
    @(negedge clk); #1;
    chk("D refill_req", bus.refill_req, 1);
    @(negedge clk); flush = 1'b1;
    @(negedge clk); flush = 1'b0;
    #1 chk("D req held", bus.refill_req, 1);
    @(negedge clk);
    bus.refill_ack = 1'b1; bus.refill_result.phy_addr = 32'h0060_0000;
    bus.refill_result.miss = 1'b0; bus.refill_result.valid = 1'b1;
    bus.refill_result.dirty = 1'b1; bus.refill_result.cache_flag = 3'd3; bus.refill_global = 1'b1;
    @(negedge clk); bus.refill_ack = 1'b0;
    #1;
    chk("D dropped", bus.resp_valid[0], 0);
    chk("D req low after ack", bus.refill_req, 0);
    bus.req_vaddr[1] = 32'h0009_0000; bus.req_vaddr[2] = 32'h0070_0000; bus.req_valid = 3'b111;
    #1;
    chk("D entries flushed", bus.resp_valid[1], 0);
    chk("D fault flushed", bus.resp_valid[2], 0);
    bus.req_valid = 3'b001;
    do_refill("D2", 32'h0060_0000, 20'h00600, 1'b0, 1'b1, 1'b1, 1'b1, 3'd3, 0);
    chk("D2 hit", bus.resp_valid[0], 1);
    chk("D2 phy", bus.resp_result[0].phy_addr, 32'h0060_0000);
    bus.req_valid = '0;

    // Flush coincident with the IDLE->REQ decision: flush wins.
    @(negedge clk);
    bus.req_vaddr[0] = 32'h00B0_0000; bus.req_valid = 3'b001; flush = 1'b1;
    #1 chk("F stall", bus.resp_valid[0], 0);
    @(negedge clk); flush = 1'b0;
    #1 chk("F stayed idle", bus.refill_req, 0);
    @(negedge clk); #1;
    chk("F refill after", bus.refill_req, 1);
    do_refill("F", 32'h00B0_0000, 20'h00B00, 1'b0, 1'b1, 1'b0, 1'b1, 3'd3, 0);
    chk("F hit", bus.resp_valid[0], 1);
    bus.req_valid = '0;

`ifdef MMU_UTLB_PERF_EN
    @(negedge clk); #1;
    h0 = perf_hit; m0 = perf_miss;
    @(negedge clk);
    bus.req_vaddr[0] = 32'h00B0_0000; bus.req_valid = 3'b001;
    repeat (3) @(negedge clk);
    bus.req_valid = '0;
    #1;
    chk("perf_hit delta", perf_hit, h0 + 32'd3);
    chk("perf_miss steady", perf_miss, m0);
    @(negedge clk);
    bus.req_vaddr[0] = 32'h00C0_0000; bus.req_valid = 3'b001;
    do_refill("P", 32'h00C0_0000, 20'h00C00, 1'b0, 1'b1, 1'b0, 1'b1, 3'd3, 0);
    bus.req_valid = '0;
    @(negedge clk); #1;
    chk("perf_miss delta", perf_miss, m0 + 32'd1);
    chk("perf_hit after refill", perf_hit, h0 + 32'd3);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
